// File: rtl/iob_cache_be_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iob_cache_be_arb_pkg : state encoding and round-robin helper             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package iob_cache_be_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } arb_state_t;

  // Index that sits `offset` places after `ptr` on a ring of n entries.
  // Callers keep ptr < n and 1 <= offset <= n, so one wrap is enough.
  function automatic int rr_next_idx(input int ptr, input int offset, input int n);
    int sum;
    sum = ptr + offset;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iob_cache_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iob_cache_rr_pick : combinational round-robin picker                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module iob_cache_rr_pick
  import iob_cache_be_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan from the farthest candidate back to ptr+1 so the closest one wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (i_req[rr_next_idx(32'(i_ptr), k, N)]) begin
        o_grant                            = '0;
        o_grant[rr_next_idx(32'(i_ptr), k, N)] = 1'b1;
        o_idx                              = IDX_W'(rr_next_idx(32'(i_ptr), k, N));
        o_valid                            = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/iob_cache_be_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iob_cache_be_arb : round-robin arbiter of cache back-ends onto one       |
// | memory port; IOB_CACHE_BE_ARB_LOCK_EN keeps a line refill unbroken.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module iob_cache_be_arb
  import iob_cache_be_arb_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int BE_ADDR_W     = 24,
  parameter int BE_DATA_W     = 32,
  parameter int WORD_OFFSET_W = 3
) (
  input  logic                         clk_i,
  input  logic                         arst_n_i,
  input  logic [N_REQ-1:0]             m_req_i,
  input  logic [N_REQ*BE_ADDR_W-1:0]   m_addr_i,
  input  logic [N_REQ*BE_DATA_W-1:0]   m_wdata_i,
  input  logic [N_REQ*BE_DATA_W/8-1:0] m_wstrb_i,
  output logic [BE_DATA_W-1:0]         m_rdata_o,
  output logic [N_REQ-1:0]             m_ack_o,
  output logic                         s_req_o,
  output logic [BE_ADDR_W-1:0]         s_addr_o,
  output logic [BE_DATA_W-1:0]         s_wdata_o,
  output logic [BE_DATA_W/8-1:0]       s_wstrb_o,
  input  logic [BE_DATA_W-1:0]         s_rdata_i,
  input  logic                         s_ack_i,
  output logic [N_REQ-1:0]             grant_o
);

  localparam int c_IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_STRB_W = BE_DATA_W / 8;

  arb_state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0]     r_grant, w_grant_nxt;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [c_IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [N_REQ-1:0]     w_pick_grant;
  logic [c_IDX_W-1:0]   w_pick_idx;
  logic                 w_pick_valid;
  logic                 w_owned;
  logic [c_STRB_W-1:0]  w_sel_wstrb;

  iob_cache_rr_pick #(
    .N     (N_REQ),
    .IDX_W (c_IDX_W)
  ) u_pick (
    .i_req   (m_req_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // The owner's request fields are muxed straight through; idle port reads as zero.
  assign w_owned     = |r_grant;
  assign w_sel_wstrb = m_wstrb_i[r_idx*c_STRB_W +: c_STRB_W];
  assign s_addr_o    = w_owned ? m_addr_i[r_idx*BE_ADDR_W +: BE_ADDR_W] : '0;
  assign s_wdata_o   = w_owned ? m_wdata_i[r_idx*BE_DATA_W +: BE_DATA_W] : '0;
  assign s_wstrb_o   = w_owned ? w_sel_wstrb : '0;
  assign m_rdata_o   = s_rdata_i;
  assign grant_o     = r_grant;

`ifdef IOB_CACHE_BE_ARB_LOCK_EN
  localparam logic [WORD_OFFSET_W-1:0] c_BEAT_LAST = '1;
  logic [WORD_OFFSET_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic                     w_hold_line;

  assign w_hold_line = (w_sel_wstrb == '0) && (r_beat_cnt != c_BEAT_LAST);
`else
  logic [WORD_OFFSET_W-1:0] w_unused_word_offset;
  assign w_unused_word_offset = '0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_idx_nxt    = r_idx;
    w_rr_ptr_nxt = r_rr_ptr;
    s_req_o      = 1'b0;
    m_ack_o      = '0;
`ifdef IOB_CACHE_BE_ARB_LOCK_EN
    w_beat_cnt_nxt = r_beat_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt = w_pick_grant;
          w_idx_nxt   = w_pick_idx;
          w_state_nxt = ISSUE;
`ifdef IOB_CACHE_BE_ARB_LOCK_EN
          w_beat_cnt_nxt = '0;
`endif
        end
      end
      ISSUE: begin
        s_req_o     = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (s_ack_i) begin
          m_ack_o      = r_grant;
          w_rr_ptr_nxt = r_idx;
`ifdef IOB_CACHE_BE_ARB_LOCK_EN
          if (w_hold_line) begin
            w_state_nxt    = HOLD;
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end else begin
            w_state_nxt    = IDLE;
            w_grant_nxt    = '0;
            w_beat_cnt_nxt = '0;
          end
`else
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
`endif
        end
      end
      HOLD: begin
`ifdef IOB_CACHE_BE_ARB_LOCK_EN
        if (m_req_i[r_idx]) begin
          w_state_nxt = ISSUE;
        end
`else
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_idx    <= '0;
      r_rr_ptr <= c_IDX_W'(N_REQ - 1);
`ifdef IOB_CACHE_BE_ARB_LOCK_EN
      r_beat_cnt <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_idx    <= w_idx_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
`ifdef IOB_CACHE_BE_ARB_LOCK_EN
      r_beat_cnt <= w_beat_cnt_nxt;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iob_cache_be_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iob_cache_be_arb : bench for iob_cache_be_arb with a delayed memory   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_iob_cache_be_arb;

  localparam int N_REQ = 2;
  localparam int AW    = 24;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;

  logic                  clk_i    = 1'b0;
  logic                  arst_n_i = 1'b0;
  logic [N_REQ-1:0]      m_req_i;
  logic [N_REQ*AW-1:0]   m_addr_i;
  logic [N_REQ*DW-1:0]   m_wdata_i;
  logic [N_REQ*SW-1:0]   m_wstrb_i;
  logic [DW-1:0]         m_rdata_o;
  logic [N_REQ-1:0]      m_ack_o;
  logic                  s_req_o;
  logic [AW-1:0]         s_addr_o;
  logic [DW-1:0]         s_wdata_o;
  logic [SW-1:0]         s_wstrb_o;
  logic [DW-1:0]         s_rdata_i;
  logic                  s_ack_i;
  logic [N_REQ-1:0]      grant_o;
  logic                  mem_ack;
  logic                  inject_ack;

  assign s_ack_i = mem_ack | inject_ack;

  always #5 clk_i = ~clk_i;

  iob_cache_be_arb #(
    .N_REQ(N_REQ), .BE_ADDR_W(AW), .BE_DATA_W(DW), .WORD_OFFSET_W(3)
  ) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
    .m_rdata_o(m_rdata_o), .m_ack_o(m_ack_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory with a programmable ack delay (cycles after the s_req_o cycle).
  logic [DW-1:0] mem [0:255];
  logic          mem_loaded = 1'b0;
  int            mem_delay  = 1;
  int            mem_cnt;
  logic          mem_pend;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;

  task automatic mem_access(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    logic [DW-1:0] w;
    w = mem[a[7:0]];
    s_rdata_i <= w;
    for (int b = 0; b < SW; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
    mem[a[7:0]] <= w;
  endtask

  always @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
      mem_ack  <= 1'b0;
      if (!mem_loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= '0;
        mem[8'h10] <= 32'hDEADBEEF;
        mem_loaded <= 1'b1;
      end
    end else begin
      mem_ack <= 1'b0;
      if (s_req_o && mem_delay <= 1) begin
        mem_ack <= 1'b1;
        mem_access(s_addr_o, s_wdata_o, s_wstrb_o);
      end else if (s_req_o) begin
        mem_pend  <= 1'b1;
        mem_cnt   <= mem_delay - 1;
        mem_addr  <= s_addr_o;
        mem_wdata <= s_wdata_o;
        mem_wstrb <= s_wstrb_o;
      end else if (mem_pend) begin
        if (mem_cnt <= 1) begin
          mem_ack  <= 1'b1;
          mem_pend <= 1'b0;
          mem_access(mem_addr, mem_wdata, mem_wstrb);
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
    end
  end

  // Scoreboard: expected acks in order, popped when the DUT acks.
  typedef struct {
    int            idx;
    logic          chk;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk_i) begin
    if (m_ack_o != '0) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: m_ack_o=%b with nothing expected at %0t", m_ack_o, $time);
      end else begin
        mon_e = sb.pop_front();
        check("ack_owner", 64'(m_ack_o), 64'(2'b01 << mon_e.idx));
        check("ack_grant", 64'(grant_o), 64'(2'b01 << mon_e.idx));
        if (mon_e.chk) check("ack_rdata", 64'(m_rdata_o), 64'(mon_e.rdata));
      end
    end
  end

  function automatic exp_t mk_exp(input int idx, input logic chk, input logic [DW-1:0] rd);
    exp_t e;
    e.idx = idx; e.chk = chk; e.rdata = rd;
    return e;
  endfunction

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } txn_t;
  txn_t q0[$];
  txn_t q1[$];

  function automatic txn_t mk_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    txn_t t;
    t.addr = a; t.wdata = d; t.wstrb = s;
    return t;
  endfunction

  // Requesters hold each request level until acked, then present the next one.
  task automatic run_traffic(input int budget);
    int cyc;
    logic [N_REQ-1:0] acks;
    cyc = 0;
    while ((q0.size() > 0 || q1.size() > 0) && cyc < budget) begin
      m_req_i = {q1.size() > 0, q0.size() > 0};
      if (q0.size() > 0) begin
        m_addr_i[0 +: AW] = q0[0].addr; m_wdata_i[0 +: DW] = q0[0].wdata; m_wstrb_i[0 +: SW] = q0[0].wstrb;
      end
      if (q1.size() > 0) begin
        m_addr_i[AW +: AW] = q1[0].addr; m_wdata_i[DW +: DW] = q1[0].wdata; m_wstrb_i[SW +: SW] = q1[0].wstrb;
      end
      @(negedge clk_i);
      acks = m_ack_o;
      @(posedge clk_i); #1;
      if (acks[0]) void'(q0.pop_front());
      if (acks[1]) void'(q1.pop_front());
      cyc++;
    end
    m_req_i = '0;
    if (q0.size() > 0 || q1.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL traffic_timeout: %0d/%0d beats left after %0d cycles", q0.size(), q1.size(), cyc);
    end
    q0.delete();
    q1.delete();
    check("sb_drained", 64'(sb.size()), 64'(0));
  endtask

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            dly;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  task automatic single_beat(input vec_t v);
    logic [N_REQ-1:0] oh;
    oh = N_REQ'(1) << v.idx;
    mem_delay = v.dly;
    m_addr_i[v.idx*AW +: AW]  = v.addr;
    m_wdata_i[v.idx*DW +: DW] = v.wdata;
    m_wstrb_i[v.idx*SW +: SW] = v.wstrb;
    m_req_i = oh;
    sb.push_back(mk_exp(v.idx, v.wstrb == '0, v.exp_rdata));
    @(negedge clk_i);
    check("c0_s_req", 64'(s_req_o), 64'(0));
    check("c0_grant", 64'(grant_o), 64'(0));
    for (int k = 1; k <= v.dly + 1; k++) begin
      @(negedge clk_i);
      check("s_req_pulse", 64'(s_req_o), 64'(k == 1));
      check("ack_timing", 64'(m_ack_o), (k == v.dly + 1) ? 64'(oh) : 64'(0));
      check("grant_held", 64'(grant_o), 64'(oh));
      if (k == 1) begin
        check("s_addr", 64'(s_addr_o), 64'(v.addr));
        check("s_wdata", 64'(s_wdata_o), 64'(v.wdata));
        check("s_wstrb", 64'(s_wstrb_o), 64'(v.wstrb));
      end
    end
    @(posedge clk_i); #1;
    m_req_i = '0;
    @(negedge clk_i);
    check("idle_grant", 64'(grant_o), 64'(0));
    check("idle_s_req", 64'(s_req_o), 64'(0));
    check("idle_s_addr", 64'(s_addr_o), 64'(0));
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    arst_n_i   = 1'b0;
    m_req_i    = '0;
    inject_ack = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_s_req", 64'(s_req_o), 64'(0));
    check("rst_m_ack", 64'(m_ack_o), 64'(0));
    check("rst_grant", 64'(grant_o), 64'(0));
    check("rst_s_addr", 64'(s_addr_o), 64'(0));
    @(posedge clk_i); #1;
    arst_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  vec_t tbl[6];

  initial begin
    m_req_i = '0; m_addr_i = '0; m_wdata_i = '0; m_wstrb_i = '0; inject_ack = 1'b0;

    tbl[0] = '{idx: 0, addr: 24'h000010, wdata: 32'h0,        wstrb: 4'h0, dly: 1, exp_rdata: 32'hDEADBEEF};
    tbl[1] = '{idx: 1, addr: 24'h000024, wdata: 32'h12345678, wstrb: 4'hF, dly: 1, exp_rdata: 32'h0};
    tbl[2] = '{idx: 0, addr: 24'h000024, wdata: 32'h0,        wstrb: 4'h0, dly: 5, exp_rdata: 32'h12345678};
    tbl[3] = '{idx: 1, addr: 24'h000024, wdata: 32'hCAFEF00D, wstrb: 4'h5, dly: 2, exp_rdata: 32'h0};
    tbl[4] = '{idx: 1, addr: 24'h000024, wdata: 32'h0,        wstrb: 4'h0, dly: 3, exp_rdata: 32'h12FE560D};
    tbl[5] = '{idx: 0, addr: 24'h000010, wdata: 32'h0,        wstrb: 4'h0, dly: 1, exp_rdata: 32'hDEADBEEF};

    do_reset();

    // Contention straight after reset: rr_ptr=1 so requester 0 goes first.
    mem_delay = 1;
    q0.push_back(mk_txn(24'h20, 32'hAAAA5555, 4'hF));
    q1.push_back(mk_txn(24'h20, 32'h0, 4'h0));
    sb.push_back(mk_exp(0, 1'b0, 32'h0));
    sb.push_back(mk_exp(1, 1'b1, 32'hAAAA5555));
    run_traffic(100);

`ifndef IOB_CACHE_BE_ARB_LOCK_EN
    // Fairness: last served was 1, so the rotation resumes at 0.
    for (int i = 0; i < 6; i++) begin
      q0.push_back(mk_txn(24'h10, 32'h0, 4'h0));
      q1.push_back(mk_txn(24'h20, 32'h0, 4'h0));
      sb.push_back(mk_exp(0, 1'b1, 32'hDEADBEEF));
      sb.push_back(mk_exp(1, 1'b1, 32'hAAAA5555));
    end
    run_traffic(200);

    for (int i = 0; i < 6; i++) single_beat(tbl[i]);

    // Reset asserted while the beat sits in WAIT, then a stale ack.
    mem_delay = 5;
    m_addr_i[0 +: AW] = 24'h10; m_wstrb_i[0 +: SW] = '0; m_req_i = 2'b01;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("wait_grant", 64'(grant_o), 64'(2'b01));
    check("wait_s_req", 64'(s_req_o), 64'(0));
    arst_n_i = 1'b0;
    m_req_i  = '0;
    #1;
    check("midrst_grant", 64'(grant_o), 64'(0));
    check("midrst_s_req", 64'(s_req_o), 64'(0));
    check("midrst_m_ack", 64'(m_ack_o), 64'(0));
    @(posedge clk_i); #1;
    arst_n_i   = 1'b1;
    inject_ack = 1'b1;
    @(negedge clk_i);
    check("stale_m_ack", 64'(m_ack_o), 64'(0));
    check("stale_grant", 64'(grant_o), 64'(0));
    check("stale_s_req", 64'(s_req_o), 64'(0));
    @(posedge clk_i); #1;
    inject_ack = 1'b0;
    single_beat('{idx: 1, addr: 24'h000024, wdata: 32'h0, wstrb: 4'h0, dly: 1, exp_rdata: 32'h12FE560D});
    check("post_rst_sb", 64'(sb.size()), 64'(0));
`endif

    // Eight reads from requester 0 while requester 1 waits.
    do_reset();
    mem_delay = 1;
    for (int i = 0; i < 8; i++) q0.push_back(mk_txn(24'h10, 32'h0, 4'h0));
    q1.push_back(mk_txn(24'h20, 32'h0, 4'h0));
`ifdef IOB_CACHE_BE_ARB_LOCK_EN
    for (int i = 0; i < 8; i++) sb.push_back(mk_exp(0, 1'b1, 32'hDEADBEEF));
    sb.push_back(mk_exp(1, 1'b1, 32'hAAAA5555));
`else
    sb.push_back(mk_exp(0, 1'b1, 32'hDEADBEEF));
    sb.push_back(mk_exp(1, 1'b1, 32'hAAAA5555));
    for (int i = 0; i < 7; i++) sb.push_back(mk_exp(0, 1'b1, 32'hDEADBEEF));
`endif
    run_traffic(200);

    repeat (2) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire

// File: doc/iob_cache_be_arb.md
Name: iob_cache_be_arb

Overview:
- Round-robin arbiter that lets N_REQ cache back-end native ports share one back-end memory port (for example, I-cache and D-cache into one RAM or AXI bridge).
- Sits between the cache back-ends (be_*) and the memory.
- Sequences each beat as issue, then wait-for-ack.
- Supports an optional line-refill lock so a cache line refill is not interleaved with other requesters.

Parameters:
- N_REQ, 2, number of requesters (≥2).
- BE_ADDR_W, 24, back-end address width.
- BE_DATA_W, 32, back-end data width.
- WORD_OFFSET_W, 3, log2 of words per cache line (used by the lock feature only).

Ports:
- clk_i  in  1  system clock.
- arst_n_i  in  1  asynchronous reset, active-low.
- m_req_i  in  N_REQ  per-requester request; level, held until its m_ack_o.
- m_addr_i  in  N_REQ*BE_ADDR_W  packed addresses; requester i occupies bits [i*BE_ADDR_W +: BE_ADDR_W].
- m_wdata_i  in  N_REQ*BE_DATA_W  packed write data.
- m_wstrb_i  in  N_REQ*BE_DATA_W/8  packed byte strobes; all-zero means read.
- m_rdata_o  out  BE_DATA_W  read data, broadcast to all requesters (equals s_rdata_i).
- m_ack_o  out  N_REQ  one-hot, one-cycle ack to the granted requester.
- s_req_o  out  1  one-cycle request pulse per beat to memory.
- s_addr_o  out  BE_ADDR_W  granted address.
- s_wdata_o  out  BE_DATA_W  granted write data.
- s_wstrb_o  out  BE_DATA_W/8  granted strobes.
- s_rdata_i  in  BE_DATA_W  memory read data, valid with s_ack_i.
- s_ack_i  in  1  memory ack pulse, arriving ≥1 cycle after s_req_o.
- grant_o  out  N_REQ  one-hot current owner; 0 when IDLE.

Behaviour:
- Reset (async, arst_n_i=0): state=IDLE, grant=0, rr_ptr=N_REQ-1, beat_cnt=0. Outputs: s_req_o=0, m_ack_o=0, grant_o=0.
  - Asserting reset mid-transaction abandons the beat; any late s_ack_i is ignored in IDLE.
- IDLE: if any m_req_i bit is set, register grant = first requester set at index rr_ptr+1, rr_ptr+2, … (modulo N_REQ); go to ISSUE. Otherwise stay.
- ISSUE (exactly 1 cycle): s_req_o=1; go to WAIT.
- WAIT: s_req_o=0.
  - On s_ack_i: m_ack_o[g]=1 in the same cycle (combinational pass-through); rr_ptr<=g; go to IDLE.
  - In lock mode, go to HOLD instead (see Optional Feature).
- Address/data path: s_addr_o, s_wdata_o and s_wstrb_o are muxed from the registered grant index g in every state. They are driven 0 when grant=0. Requesters must keep their inputs stable until ack.
- m_rdata_o = s_rdata_i always. It is qualified only by m_ack_o.
- Latency with a 1-cycle memory: m_req at cycle 0 → s_req_o at cycle 1 → s_ack_i / m_ack_o at cycle 2 → IDLE at cycle 3. Throughput is 1 beat per 3 cycles.
- Fairness:
  - The most recently served requester has lowest priority at the next arbitration.
  - With all requests continuously asserted, grants rotate 0,1,…,N_REQ-1,0.
- Simultaneous events:
  - A requester dropping m_req_i while granted (illegal before ack) does not abort the beat.
  - A new request arriving during ISSUE/WAIT waits for IDLE.
  - An s_ack_i outside WAIT is ignored.

Optional Feature:
- Macro: IOB_CACHE_BE_ARB_LOCK_EN.
- Defined:
  - A read beat (granted m_wstrb all-zero) with beat_cnt < 2**WORD_OFFSET_W-1 goes WAIT→HOLD on s_ack_i and increments beat_cnt.
  - HOLD keeps the grant and ignores other requesters. When m_req_i[g]=1, go to ISSUE.
  - The last beat (beat_cnt = 2**WORD_OFFSET_W-1) or any write beat returns to IDLE and clears beat_cnt.
  - beat_cnt clears on every new grant.
  - HOLD has no timeout; requesters guarantee a full line refill.
- Undefined: the HOLD state and beat_cnt are not generated; every beat re-arbitrates.

Decomposition:
- Package iob_cache_be_arb_pkg holds:
  - state encoding constants IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, HOLD=2'd3;
  - the function for the round-robin next-index.
- Sub-module iob_cache_rr_pick: combinational round-robin picker (req vector plus pointer in, one-hot grant and index out). It is reusable by other arbiters.

Test Plan:
- Single read: N_REQ=2, 1-cycle memory, m_req_i=2'b01, addr 0x000010, memory word 0xDEADBEEF → s_req_o pulse at cycle 1 with s_addr_o=0x000010; m_ack_o=2'b01 and m_rdata_o=0xDEADBEEF at cycle 2; grant_o=0 at cycle 3.
- Contention: both requesters hold requests (req0 write 0xAAAA5555 with wstrb=4'hF to 0x20, req1 read 0x20) → req0 served first (rr_ptr=1 after reset); req1's read returns 0xAAAA5555; grant order 01,10.
- Fairness: both requesters assert 6 requests each continuously → grant_o sequence alternates 01,10,01,10…; no requester is served twice in a row.
- Slow memory: s_ack_i delayed 5 cycles → s_req_o stays a single pulse; state holds WAIT; m_ack_o asserts only in the ack cycle.
- Reset mid-beat: arst_n_i low in WAIT, then a stale s_ack_i after release → all outputs 0; no m_ack_o; the next request is arbitrated normally.
- Lock (IOB_CACHE_BE_ARB_LOCK_EN, WORD_OFFSET_W=3): req0 issues 8 read beats while req1 requests → all 8 beats go to req0 with grant_o=01 throughout; req1 is granted after beat 8. Without the macro, grants interleave.
